conv1_acc_requant: RTL and testbench

- Downstream of the conv1 14s×6u product multiplier. Consumes its 20-bit signed products as a valid/ready stream and accumulates one kernel window of TAPS products.
- At window end, adds the per-channel bias and right-shifts with round-half-up. It then saturates back to the 14-bit signed activation format and applies optional ReLU.
- Emits one activation per window to the conv1 output buffer writer.

---
 rtl/conv1_pkg.sv | 32 +++
 rtl/conv1_requant_sat.sv | 30 +++
 rtl/conv1_acc_requant.sv | 109 ++++++++++
 tb/tb_conv1_acc_requant.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// Shared constants, FSM state type and fixed-width requantisation helper for the conv1 stages.
package conv1_pkg;

  localparam int CONV1_TAPS   = 25;
  localparam int CONV1_PROD_W = 20;
  localparam int CONV1_ACC_W  = 26;
  localparam int CONV1_DATA_W = 14;
  localparam int CONV1_SHIFT  = 6;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_ACCUM = 1'b1
  } conv1_state_e;

  // Round-half-up right shift then saturate to the activation range (no ReLU).
  function automatic logic signed [CONV1_DATA_W-1:0] sat_round(
    input logic signed [CONV1_ACC_W-1:0] acc,
    input int unsigned                   shift
  );
    logic signed [CONV1_ACC_W:0] wide;
    logic signed [CONV1_ACC_W:0] maxv;
    logic signed [CONV1_ACC_W:0] minv;
    maxv = (CONV1_ACC_W+1)'((64'sd1 <<< (CONV1_DATA_W - 1)) - 64'sd1);
    minv = ~maxv;
    wide = {acc[CONV1_ACC_W-1], acc} + ((CONV1_ACC_W+1)'(1) <<< (shift - 1));
    wide = wide >>> shift;
    if (wide > maxv)      sat_round = maxv[CONV1_DATA_W-1:0];
    else if (wide < minv) sat_round = minv[CONV1_DATA_W-1:0];
    else                  sat_round = wide[CONV1_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv1_requant_sat.sv
// Combinational requantiser: round-half-up arithmetic shift, saturation to DATA_W, optional ReLU.
module conv1_requant_sat #(
  parameter int ACC_W  = 26,
  parameter int DATA_W = 14,
  parameter int SHIFT  = 6,
  parameter int RELU   = 1
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] act
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [RW-1:0] rounded;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    act     = '0;
    rounded = ($signed({acc[ACC_W-1], acc}) + HALF) >>> SHIFT;
    if (rounded > MAXV)      act = MAXV[DATA_W-1:0];
    else if (rounded < MINV) act = MINV[DATA_W-1:0];
    else                     act = rounded[DATA_W-1:0];
    if (RELU != 0 && rounded[RW-1]) act = '0;
  end

endmodule

// File: rtl/conv1_acc_requant.sv
// Accumulates TAPS signed products per window, adds bias, requantises and emits one activation per window.
module conv1_acc_requant
  import conv1_pkg::*;
#(
  parameter int TAPS   = CONV1_TAPS,
  parameter int PROD_W = CONV1_PROD_W,
  parameter int ACC_W  = CONV1_ACC_W,
  parameter int DATA_W = CONV1_DATA_W,
  parameter int SHIFT  = CONV1_SHIFT,
  parameter int RELU   = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic [DATA_W-1:0] bias_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_last
);

  localparam int CNT_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic [1:0]        rst_sync;
  logic              rst_n_int;
  logic              run_q;
  conv1_state_e      state, next_state;
  logic [ACC_W-1:0]  acc, acc_d, sum, prod_ext, bias_ext;
  logic [CNT_W-1:0]  tap_cnt, cnt_d;
  logic              beat, win_end;
  logic [DATA_W-1:0] requant;

  // NOTE: reset asserts asynchronously but releases through two flops, so no state flop sees a
  // reset edge racing the clock; run_q then holds the input closed until the core is out of reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign prod_ready = run_q && !(out_valid && !out_ready);
  assign beat       = prod_valid && prod_ready;
  assign prod_ext   = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign bias_ext   = {{(ACC_W-DATA_W){bias_in[DATA_W-1]}}, bias_in} << SHIFT;

  always_comb begin
    next_state = state;
    acc_d      = acc;
    cnt_d      = tap_cnt;
    win_end    = 1'b0;
    sum        = (state == ST_FIRST) ? bias_ext + prod_ext : acc + prod_ext;
    if (beat) begin
      if (state == ST_FIRST) begin
        acc_d      = sum;
        cnt_d      = CNT_W'(1);
        next_state = ST_ACCUM;
      end else if (tap_cnt == LAST_TAP) begin
        // The tap counter alone defines the window boundary; prod_last is only checked against it.
        win_end    = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
        next_state = ST_FIRST;
      end else begin
        acc_d = sum;
        cnt_d = tap_cnt + CNT_W'(1);
      end
    end
  end

  conv1_requant_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT),
    .RELU   (RELU)
  ) u_requant (
    .acc (sum),
    .act (requant)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      run_q     <= 1'b0;
      state     <= ST_FIRST;
      acc       <= '0;
      tap_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err_last  <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state   <= next_state;
      acc     <= acc_d;
      tap_cnt <= cnt_d;
      if (win_end) begin
        out_valid <= 1'b1;
        out_data  <= requant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (beat && (prod_last != win_end)) err_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv1_acc_requant.sv
// Directed + randomized bench for conv1_acc_requant; RELU=1 and RELU=0 instances share one stimulus.
module tb_conv1_acc_requant;

  localparam int TAPS = 25;
  typedef int win_t[TAPS];

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [19:0] prod_data  = '0;
  logic        prod_valid = 1'b0;
  logic        prod_last  = 1'b0;
  logic [13:0] bias_in    = '0;
  logic        out_ready  = 1'b1;
  logic        pr1, ov1, err1, pr0, ov0, err0;
  logic [13:0] od1, od0;

  int checks = 0;
  int passed = 0;
  logic [13:0] got1_q[$], got0_q[$], exp1_q[$], exp0_q[$];

  always #5 ap_clk = ~ap_clk;

  conv1_acc_requant #(.RELU(1)) dut_r1 (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (pr1),
    .bias_in    (bias_in),
    .out_data   (od1),
    .out_valid  (ov1),
    .out_ready  (out_ready),
    .err_last   (err1)
  );

  conv1_acc_requant #(.RELU(0)) dut_r0 (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (pr0),
    .bias_in    (bias_in),
    .out_data   (od0),
    .out_valid  (ov0),
    .out_ready  (out_ready),
    .err_last   (err0)
  );

  // Results are taken on handshake; inputs only change just after posedge, so negedge sees them settled.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (ov1 && out_ready) got1_q.push_back(od1);
      if (ov0 && out_ready) got0_q.push_back(od0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Window sum plus scaled bias, rounded half up, clamped to 14-bit signed, optional ReLU.
  function automatic logic [13:0] model(input win_t w, input int bias, input bit relu);
    longint s;
    s = longint'(bias) * 64;
    foreach (w[i]) s += longint'(w[i]);
    s = (s + 32) >>> 6;
    if (s > 8191)  s = 8191;
    if (s < -8192) s = -8192;
    if (relu && s < 0) s = 0;
    return s[13:0];
  endfunction

  function automatic win_t const_win(input int v);
    win_t w;
    foreach (w[i]) w[i] = v;
    return w;
  endfunction

  function automatic win_t rand_win(input int m);
    win_t w;
    foreach (w[i]) w[i] = int'($urandom_range(0, 2 * m)) - m;
    return w;
  endfunction

  task automatic send_beat(input int d, input bit last, input int b);
    int n;
    n = 0;
    prod_valid = 1'b1;
    prod_data  = d[19:0];
    prod_last  = last;
    bias_in    = b[13:0];
    @(negedge ap_clk);
    while (!pr1 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", pr1, 1);
    @(posedge ap_clk);
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic send_window(input win_t w, input int bias, input int last_at);
    exp1_q.push_back(model(w, bias, 1'b1));
    exp0_q.push_back(model(w, bias, 1'b0));
    for (int i = 0; i < TAPS; i++) begin
      // Bias is only meaningful on the first beat; scramble it elsewhere.
      send_beat(w[i], i == last_at, (i == 0) ? bias : int'($urandom_range(0, 16383)) - 8192);
      if (i == TAPS - 1) begin
        check("latency_ov", ov1, 1);
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge ap_clk);
        #1;
      end
    end
  endtask

  task automatic collect(input string tag);
    int n;
    n = 0;
    while ((got1_q.size() == 0 || got0_q.size() == 0) && n < 200) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check({tag, "_avail"}, (got1_q.size() > 0 && got0_q.size() > 0), 1);
    if (got1_q.size() > 0 && got0_q.size() > 0 && exp1_q.size() > 0 && exp0_q.size() > 0) begin
      check({tag, "_relu1"}, got1_q.pop_front(), exp1_q.pop_front());
      check({tag, "_relu0"}, got0_q.pop_front(), exp0_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t w, wa, wb;
    int   ba, bb, n;
    logic [13:0] held;

    // Reset state
    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_ready_r1", pr1, 0);
    check("rst_ready_r0", pr0, 0);
    check("rst_valid", ov1, 0);
    check("rst_data", od1, 0);
    check("rst_err", err1, 0);
    ap_rst_n = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
    check("post_rst_ready", pr1, 1);

    // Basic window, single pulse
    send_window(const_win(64), 0, TAPS - 1);
    collect("basic64");
    repeat (3) @(posedge ap_clk);
    #1;
    check("one_pulse", got1_q.size(), 0);
    check("valid_dropped", ov1, 0);
    check("err_clean", err1, 0);

    // Saturation
    send_window(const_win(524287), 8191, TAPS - 1);
    collect("sat_pos");
    send_window(const_win(-524288), 0, TAPS - 1);
    collect("sat_neg");

    // Rounding
    w = const_win(0); w[0] = 32;
    send_window(w, 0, TAPS - 1);
    collect("round_p32");
    w[0] = -32;
    send_window(w, 0, TAPS - 1);
    collect("round_m32");
    w[0] = -33;
    send_window(w, 0, TAPS - 1);
    collect("round_m33");

    // Negative result with and without ReLU
    send_window(const_win(-64), 0, TAPS - 1);
    collect("neg25");

    // Random windows, wide and narrow ranges
    for (int k = 0; k < 6; k++) begin
      send_window(rand_win((k < 3) ? 524288 : 3000), int'($urandom_range(0, 16383)) - 8192, TAPS - 1);
      collect("random");
    end

    // Backpressure: first result held 5 cycles while the next window is already streaming
    out_ready = 1'b0;
    wa = rand_win(3000); ba = int'($urandom_range(0, 1000)) - 500;
    wb = rand_win(3000); bb = int'($urandom_range(0, 1000)) - 500;
    fork
      begin : drive
        send_window(wa, ba, TAPS - 1);
        send_window(wb, bb, TAPS - 1);
      end
      begin : hold
        n = 0;
        while (!ov1 && n < 500) begin
          @(negedge ap_clk);
          n++;
        end
        held = od1;
        for (int k = 0; k < 5; k++) begin
          @(negedge ap_clk);
          check("bp_ready_low", pr1, 0);
          check("bp_data_stable", od1, held);
        end
        @(posedge ap_clk);
        #1 out_ready = 1'b1;
      end
    join
    collect("bp_first");
    collect("bp_second");

    // Reset in the middle of a window discards the partial sum
    for (int i = 0; i < 10; i++) send_beat(64, 1'b0, 0);
    ap_rst_n = 1'b0;
    #2;
    check("midrst_ready", pr1, 0);
    check("midrst_valid", ov1, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
    send_window(const_win(64), 0, TAPS - 1);
    collect("after_midrst");
    check("after_midrst_err", err1, 0);

    // Framing error: prod_last on beat 24 instead of 25; output still follows the counter
    send_window(const_win(64), 0, TAPS - 2);
    collect("frame_err_out");
    check("frame_err_r1", err1, 1);
    check("frame_err_r0", err0, 1);
    send_window(rand_win(2000), 100, TAPS - 1);
    collect("frame_after");
    check("frame_err_sticky", err1, 1);

    check("exp_drained", exp1_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
